// File: rtl/transfer_sequencer_pkg.sv
// transfer_sequencer_pkg: state encodings, error codes and output decode
// shared by the transfer sequencer, its watchdog and the top level.
package transfer_sequencer_pkg;

    // Encoding is visible on the state port (debug / seven-segment).
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RECEIVE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } seqState_t;

    localparam logic [3:0] ERR_NONE    = 4'h0;
    localparam logic [3:0] ERR_ABORT   = 4'hA;
    localparam logic [3:0] ERR_EMPTY   = 4'hE;
    localparam logic [3:0] ERR_TIMEOUT = 4'hF;

    typedef struct packed {
        logic comEnable;
        logic outEnable;
        logic pathReset;
        logic busy;
        logic done;
        logic error;
    } seqOuts_t;

    // While reset is held the datapath is kept in reset as well.
    localparam seqOuts_t RESET_OUTS = '{comEnable: 1'b0, outEnable: 1'b0, pathReset: 1'b1,
                                        busy: 1'b0, done: 1'b0, error: 1'b0};

    // Moore decode of the control outputs for a given state.
    function automatic seqOuts_t decodeOutputs(input seqState_t s);
        seqOuts_t o;
        o = '0;
        case (s)
            ST_CLEAR:   begin o.busy = 1'b1; o.pathReset = 1'b1; end
            ST_RECEIVE: begin o.busy = 1'b1; o.comEnable = 1'b1; end
            ST_DRAIN:   begin o.busy = 1'b1; o.outEnable = 1'b1; end
            ST_DONE:    o.done  = 1'b1;
            ST_ERROR:   o.error = 1'b1;
            default:    o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/transfer_sequencer_watchdog.sv
// seq_watchdog: saturating 16-bit phase counter with synchronous clear,
// count enable and an expired flag at LIMIT-1. Only used when the
// top level is built with TRANSFER_TIMEOUT_EN.
module seq_watchdog #(
    parameter int unsigned LIMIT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] cnt;
    logic [15:0] effCnt;

    // clear marks the first cycle of a phase, so it takes effect immediately
    assign effCnt  = clear ? '0 : cnt;
    assign expired = enable && (effCnt == 16'(LIMIT - 1));

    // count enabled cycles, saturating at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (effCnt == '1) ? effCnt : effCnt + 16'd1;
        end else begin
            cnt <= effCnt;
        end
    end

endmodule

// File: rtl/transfer_sequencer.sv
// transfer_sequencer: sequences the UART receive path (clear, receive,
// drain) on a start pulse, latches the frame CRC and an error code.
// Optional watchdog on RECEIVE/DRAIN: define TRANSFER_TIMEOUT_EN.
module transfer_sequencer
    import transfer_sequencer_pkg::*;
#(
    parameter int unsigned CLEAR_CYCLES   = 4,
    parameter int unsigned MIN_BYTES      = 1
`ifdef TRANSFER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       com_finish,
    input  logic [3:0] com_error,
    input  logic [7:0] crc_in,
    input  logic       fifo_empty,
    input  logic [9:0] fifo_count,
    input  logic       out_finish,
    output logic       com_enable,
    output logic       out_enable,
    output logic       path_reset,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_code,
    output logic [7:0] crc_out,
    output logic [2:0] state
);

    seqState_t   stateQ;
    seqOuts_t    outsQ;
    logic [3:0]  errCodeQ;
    logic [7:0]  crcQ;
    logic [15:0] phaseCnt;
    logic        timeoutHit;

    // Outputs are registered alongside the state: each transition loads the
    // decode of the target state, otherwise the current state is re-decoded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ   <= ST_IDLE;
            outsQ    <= RESET_OUTS;
            errCodeQ <= ERR_NONE;
            crcQ     <= '0;
            phaseCnt <= '0;
        end else begin
            outsQ <= decodeOutputs(stateQ);
            if (phaseCnt != '1) begin
                phaseCnt <= phaseCnt + 16'd1;
            end
            case (stateQ)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        stateQ   <= ST_CLEAR;
                        outsQ    <= decodeOutputs(ST_CLEAR);
                        phaseCnt <= '0;
                        errCodeQ <= ERR_NONE;
                    end
                end
                ST_CLEAR: begin
                    if (abort) begin
                        stateQ   <= ST_ERROR;
                        outsQ    <= decodeOutputs(ST_ERROR);
                        phaseCnt <= '0;
                        errCodeQ <= ERR_ABORT;
                    end else if (phaseCnt == 16'(CLEAR_CYCLES - 1)) begin
                        stateQ   <= ST_RECEIVE;
                        outsQ    <= decodeOutputs(ST_RECEIVE);
                        phaseCnt <= '0;
                    end
                end
                ST_RECEIVE: begin
                    if (abort) begin
                        stateQ   <= ST_ERROR;
                        outsQ    <= decodeOutputs(ST_ERROR);
                        phaseCnt <= '0;
                        errCodeQ <= ERR_ABORT;
                    end else if (com_finish) begin
                        if (com_error != ERR_NONE) begin
                            stateQ   <= ST_ERROR;
                            outsQ    <= decodeOutputs(ST_ERROR);
                            phaseCnt <= '0;
                            errCodeQ <= com_error;
                        end else if (32'(fifo_count) < MIN_BYTES) begin
                            stateQ   <= ST_ERROR;
                            outsQ    <= decodeOutputs(ST_ERROR);
                            phaseCnt <= '0;
                            errCodeQ <= ERR_EMPTY;
                        end else begin
                            stateQ   <= ST_DRAIN;
                            outsQ    <= decodeOutputs(ST_DRAIN);
                            phaseCnt <= '0;
                            crcQ     <= crc_in;
                        end
                    end else if (timeoutHit) begin
                        stateQ   <= ST_ERROR;
                        outsQ    <= decodeOutputs(ST_ERROR);
                        phaseCnt <= '0;
                        errCodeQ <= ERR_TIMEOUT;
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        stateQ   <= ST_ERROR;
                        outsQ    <= decodeOutputs(ST_ERROR);
                        phaseCnt <= '0;
                        errCodeQ <= ERR_ABORT;
                    end else if (out_finish) begin
                        // out_finish with data still queued keeps draining
                        if (fifo_empty) begin
                            stateQ   <= ST_DONE;
                            outsQ    <= decodeOutputs(ST_DONE);
                            phaseCnt <= '0;
                        end
                    end else if (timeoutHit) begin
                        stateQ   <= ST_ERROR;
                        outsQ    <= decodeOutputs(ST_ERROR);
                        phaseCnt <= '0;
                        errCodeQ <= ERR_TIMEOUT;
                    end
                end
                default: begin
                    stateQ   <= ST_IDLE;
                    outsQ    <= decodeOutputs(ST_IDLE);
                    phaseCnt <= '0;
                end
            endcase
        end
    end

`ifdef TRANSFER_TIMEOUT_EN
    seqState_t prevState;
    logic      firstCycle;
    logic      inPhase;

    // remember last cycle's state so the watchdog restarts on every phase entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prevState <= ST_IDLE;
        end else begin
            prevState <= stateQ;
        end
    end

    assign firstCycle = (stateQ != prevState);
    assign inPhase    = (stateQ == ST_RECEIVE) || (stateQ == ST_DRAIN);

    seq_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) uWatchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (firstCycle),
        .enable (inPhase),
        .expired(timeoutHit)
    );
`else
    assign timeoutHit = 1'b0;
`endif

    assign com_enable = outsQ.comEnable;
    assign out_enable = outsQ.outEnable;
    assign path_reset = outsQ.pathReset;
    assign busy       = outsQ.busy;
    assign done       = outsQ.done;
    assign error      = outsQ.error;
    assign err_code   = errCodeQ;
    assign crc_out    = crcQ;
    assign state      = stateQ;

endmodule

// File: tb/tb_transfer_sequencer.sv
// tb_transfer_sequencer: table-driven directed check of transfer_sequencer
// plus hand sequences for async reset and the RECEIVE watchdog.
module tb_transfer_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort, comFinish, fifoEmpty, outFinish;
    logic [3:0] comError;
    logic [7:0] crcIn;
    logic [9:0] fifoCount;
    logic       comEnable, outEnable, pathReset, busy, done, error;
    logic [3:0] errCode;
    logic [7:0] crcOut;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // flag order: busy, done, error, com_enable, out_enable, path_reset
    localparam logic [5:0] F_IDLE  = 6'b000000;
    localparam logic [5:0] F_CLEAR = 6'b100001;
    localparam logic [5:0] F_RECV  = 6'b100100;
    localparam logic [5:0] F_DRAIN = 6'b100010;
    localparam logic [5:0] F_DONE  = 6'b010000;
    localparam logic [5:0] F_ERR   = 6'b001000;
    localparam logic [5:0] F_RST   = 6'b000001;

    typedef struct {
        logic       st, ab, cf, fe, of;
        logic [3:0] ce;
        logic [7:0] crc;
        logic [9:0] fc;
        logic [2:0] expState;
        logic [5:0] expFlags;
        logic [3:0] expErr;
        logic [7:0] expCrc;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    transfer_sequencer #(
`ifdef TRANSFER_TIMEOUT_EN
        .TIMEOUT_CYCLES(16),
`endif
        .CLEAR_CYCLES(4),
        .MIN_BYTES(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .com_finish(comFinish),
        .com_error (comError),
        .crc_in    (crcIn),
        .fifo_empty(fifoEmpty),
        .fifo_count(fifoCount),
        .out_finish(outFinish),
        .com_enable(comEnable),
        .out_enable(outEnable),
        .path_reset(pathReset),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (errCode),
        .crc_out   (crcOut),
        .state     (state)
    );

    function automatic logic [20:0] actual();
        return {state, busy, done, error, comEnable, outEnable, pathReset, errCode, crcOut};
    endfunction

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got st=%0d flags=%b err=%h crc=%h expected st=%0d flags=%b err=%h crc=%h",
                     name, act[20:18], act[17:12], act[11:8], act[7:0],
                     exp[20:18], exp[17:12], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic add(input logic st, ab, cf, input logic [3:0] ce, input logic [7:0] crc,
                       input logic fe, input logic [9:0] fc, input logic of,
                       input logic [2:0] es, input logic [5:0] ef, input logic [3:0] ee,
                       input logic [7:0] ec);
        vec_t v;
        v.st = st; v.ab = ab; v.cf = cf; v.ce = ce; v.crc = crc;
        v.fe = fe; v.fc = fc; v.of = of;
        v.expState = es; v.expFlags = ef; v.expErr = ee; v.expCrc = ec;
        vecs.push_back(v);
    endtask

    task automatic addIdle(input logic [2:0] es, input logic [5:0] ef, input logic [3:0] ee,
                           input logic [7:0] ec);
        add(0, 0, 0, 4'h0, 8'h00, 0, 10'd0, 0, es, ef, ee, ec);
    endtask

    // start from IDLE/DONE/ERROR: four CLEAR cycles then RECEIVE
    task automatic addStartToRecv(input logic [7:0] ec);
        add(1, 0, 0, 4'h0, 8'h00, 0, 10'd0, 0, 3'd1, F_CLEAR, 4'h0, ec);
        repeat (3) addIdle(3'd1, F_CLEAR, 4'h0, ec);
        addIdle(3'd2, F_RECV, 4'h0, ec);
    endtask

    task automatic drive(input logic st, ab, cf, input logic [3:0] ce, input logic [7:0] crc,
                         input logic fe, input logic [9:0] fc, input logic of);
        start = st; abort = ab; comFinish = cf; comError = ce; crcIn = crc;
        fifoEmpty = fe; fifoCount = fc; outFinish = of;
    endtask

    initial begin
        int recvCnt;
        reset = 1'b0;
        drive(0, 0, 0, 4'h0, 8'h00, 0, 10'd0, 0);

        // full good transfer, start ignored while busy
        addIdle(3'd0, F_IDLE, 4'h0, 8'h00);
        add(1, 0, 0, 4'h0, 8'h00, 0, 10'd0, 0, 3'd1, F_CLEAR, 4'h0, 8'h00);
        add(1, 0, 0, 4'h0, 8'h00, 0, 10'd0, 0, 3'd1, F_CLEAR, 4'h0, 8'h00);
        repeat (2) addIdle(3'd1, F_CLEAR, 4'h0, 8'h00);
        addIdle(3'd2, F_RECV, 4'h0, 8'h00);
        add(0, 0, 1, 4'h0, 8'h3C, 0, 10'd5, 0, 3'd3, F_DRAIN, 4'h0, 8'h3C);
        add(0, 0, 0, 4'h0, 8'h00, 0, 10'd3, 1, 3'd3, F_DRAIN, 4'h0, 8'h3C);
        addIdle(3'd3, F_DRAIN, 4'h0, 8'h3C);
        add(0, 0, 0, 4'h0, 8'h00, 1, 10'd0, 1, 3'd4, F_DONE, 4'h0, 8'h3C);
        add(0, 1, 0, 4'h0, 8'h00, 0, 10'd0, 0, 3'd4, F_DONE, 4'h0, 8'h3C);
        // COM error code propagates, abort in ERROR ignored
        addStartToRecv(8'h3C);
        add(0, 0, 1, 4'h2, 8'h55, 0, 10'd5, 0, 3'd5, F_ERR, 4'h2, 8'h3C);
        add(0, 1, 0, 4'h0, 8'h00, 0, 10'd0, 0, 3'd5, F_ERR, 4'h2, 8'h3C);
        // empty frame: crc_out must not change
        addStartToRecv(8'h3C);
        add(0, 0, 1, 4'h0, 8'h77, 0, 10'd0, 0, 3'd5, F_ERR, 4'hE, 8'h3C);
        // abort beats com_finish in the same cycle
        addStartToRecv(8'h3C);
        add(0, 1, 1, 4'h0, 8'h99, 0, 10'd5, 0, 3'd5, F_ERR, 4'hA, 8'h3C);
        // abort during CLEAR
        add(1, 0, 0, 4'h0, 8'h00, 0, 10'd0, 0, 3'd1, F_CLEAR, 4'h0, 8'h3C);
        add(0, 1, 0, 4'h0, 8'h00, 0, 10'd0, 0, 3'd5, F_ERR, 4'hA, 8'h3C);
        // fifo_count at the minimum is accepted; abort during DRAIN
        addStartToRecv(8'h3C);
        add(0, 0, 1, 4'h0, 8'hA5, 0, 10'd1, 0, 3'd3, F_DRAIN, 4'h0, 8'hA5);
        add(1, 0, 0, 4'h0, 8'h00, 0, 10'd1, 0, 3'd3, F_DRAIN, 4'h0, 8'hA5);
        add(0, 1, 0, 4'h0, 8'h00, 0, 10'd1, 0, 3'd5, F_ERR, 4'hA, 8'hA5);

        #12;
        check("reset_hold", actual(), {3'd0, F_RST, 4'h0, 8'h00});
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].ab, vecs[i].cf, vecs[i].ce, vecs[i].crc,
                  vecs[i].fe, vecs[i].fc, vecs[i].of);
            @(negedge clk);
            check($sformatf("vec%0d", i), actual(),
                  {vecs[i].expState, vecs[i].expFlags, vecs[i].expErr, vecs[i].expCrc});
        end

        // async reset in the middle of RECEIVE
        drive(1, 0, 0, 4'h0, 8'h00, 0, 10'd0, 0);
        @(negedge clk);
        drive(0, 0, 0, 4'h0, 8'h00, 0, 10'd0, 0);
        repeat (4) @(negedge clk);
        check("pre_reset_recv", actual(), {3'd2, F_RECV, 4'h0, 8'hA5});
        #2 reset = 1'b0;
        #1 check("async_reset", actual(), {3'd0, F_RST, 4'h0, 8'h00});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_release", actual(), {3'd0, F_IDLE, 4'h0, 8'h00});

        // RECEIVE with no com_finish
        drive(1, 0, 0, 4'h0, 8'h00, 0, 10'd0, 0);
        @(negedge clk);
        drive(0, 0, 0, 4'h0, 8'h00, 0, 10'd0, 0);
        repeat (3) @(negedge clk);
        recvCnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (state != 3'd2) break;
            recvCnt++;
        end
`ifdef TRANSFER_TIMEOUT_EN
        check("timeout_state", actual(), {3'd5, F_ERR, 4'hF, 8'h00});
        check("timeout_cycles", 21'(recvCnt), 21'd16);
`else
        check("no_timeout_cycles", 21'(recvCnt), 21'd100);
        check("no_timeout_state", actual(), {3'd2, F_RECV, 4'h0, 8'h00});
        drive(0, 1, 0, 4'h0, 8'h00, 0, 10'd0, 0);
        @(negedge clk);
        drive(0, 0, 0, 4'h0, 8'h00, 0, 10'd0, 0);
        check("late_abort", actual(), {3'd5, F_ERR, 4'hA, 8'h00});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
